// File: rtl/spi_master_multi_if.sv
// spi_master_multi_if: command and readback bus between the register decoder and the SPI master
interface spi_master_multi_if #(parameter int WIDTH = 16) ();
  logic             wvalid;
  logic             wready;
  logic [2:0]       wchan;
  logic [WIDTH-1:0] wdata;
  logic             rvalid;
  logic [2:0]       rchan;
  logic [WIDTH-1:0] rdata;
  logic             busy;
  modport master (output wvalid, wchan, wdata, input wready, rvalid, rchan, rdata, busy);
  modport slave (input wvalid, wchan, wdata, output wready, rvalid, rchan, rdata, busy);
endinterface

// File: rtl/spi_master_multi.sv
// spi_master_multi: multi-channel SPI master (CPHA 0) with a one-entry command buffer and readback strobe
module spi_master_multi #(
  parameter int NCH    = 2,
  parameter int WIDTH  = 16,
  parameter int HALF   = 1,
  parameter bit CPOL   = 1'b0,
  parameter int CS_GAP = 2
) (
  input  logic           clock,
  input  logic           reset_n,
  spi_master_multi_if.slave bus,
  output logic [NCH-1:0] sck,
  output logic [NCH-1:0] cs_n,
  output logic [NCH-1:0] mosi,
  input  logic [NCH-1:0] miso
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int GW = $clog2(CS_GAP + 1);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  state_t           state;
  logic             pending, trail;
  logic [2:0]       buf_ch, chan;
  logic [WIDTH-1:0] buf_d, shreg;
  logic [NCH-1:0]   sel;
  logic [7:0]       hcnt;
  logic [BW-1:0]    bcnt;
  logic [GW-1:0]    gcnt;
  logic             fire, take, bit_in, last_bit;
  logic [2:0]       nxt_ch;
  logic [WIDTH-1:0] nxt_d;
  logic [NCH-1:0]   nxt_sel;

  assign bus.wready = !pending;
  assign bus.busy   = state != IDLE;

  // A new transfer starts from idle or at the end of the gap; the buffer has priority over the bus.
  // An out-of-range channel gets an all-zero select so it runs the full timing with no pin activity.
  always_comb begin
    fire     = bus.wvalid && !pending;
    take     = (state == IDLE || (state == GAP && gcnt == '0)) && (pending || fire);
    nxt_ch   = pending ? buf_ch : bus.wchan;
    nxt_d    = pending ? buf_d : bus.wdata;
    nxt_sel  = 32'(nxt_ch) < NCH ? NCH'(1) << nxt_ch : '0;
    bit_in   = |(miso & sel);
    last_bit = bcnt == BW'(WIDTH - 1);
  end

  // Transfer FSM; shreg shifts the tx word out and the rx word in, so it ends holding the readback.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pending    <= 1'b0;
      trail      <= 1'b0;
      buf_ch     <= '0;
      buf_d      <= '0;
      chan       <= '0;
      shreg      <= '0;
      sel        <= '0;
      hcnt       <= '0;
      bcnt       <= '0;
      gcnt       <= '0;
      sck        <= {NCH{CPOL}};
      cs_n       <= '1;
      mosi       <= '0;
      bus.rvalid <= 1'b0;
      bus.rchan  <= '0;
      bus.rdata  <= '0;
    end else begin
      bus.rvalid <= 1'b0;
      if (fire && !take) begin
        pending <= 1'b1;
        buf_ch  <= bus.wchan;
        buf_d   <= bus.wdata;
      end else if (take) begin
        pending <= 1'b0;
      end
      if (take) begin
        state <= SETUP;
        chan  <= nxt_ch;
        sel   <= nxt_sel;
        shreg <= nxt_d;
        hcnt  <= 8'(HALF - 1);
        cs_n  <= ~nxt_sel;
        mosi  <= nxt_sel & {NCH{nxt_d[WIDTH-1]}};
      end else begin
        case (state)
          SETUP:
            if (hcnt == '0) begin
              state <= SHIFT;
              trail <= 1'b0;
              bcnt  <= '0;
              hcnt  <= 8'(HALF - 1);
              sck   <= {NCH{CPOL}} ^ sel;
            end else hcnt <= hcnt - 8'd1;
          SHIFT:
            if (hcnt != '0) hcnt <= hcnt - 8'd1;
            else if (!trail) begin
              trail <= 1'b1;
              hcnt  <= 8'(HALF - 1);
              sck   <= {NCH{CPOL}};
              shreg <= {shreg[WIDTH-2:0], bit_in};
              mosi  <= sel & {NCH{shreg[WIDTH-2] && !last_bit}};
            end else if (last_bit) begin
              state <= HOLD;
              hcnt  <= 8'(HALF - 1);
            end else begin
              trail <= 1'b0;
              bcnt  <= bcnt + BW'(1);
              hcnt  <= 8'(HALF - 1);
              sck   <= {NCH{CPOL}} ^ sel;
            end
          HOLD:
            if (hcnt == '0) begin
              state      <= GAP;
              gcnt       <= GW'(CS_GAP - 1);
              cs_n       <= '1;
              mosi       <= '0;
              bus.rvalid <= 1'b1;
              bus.rchan  <= chan;
              bus.rdata  <= |sel ? shreg : '1;
            end else hcnt <= hcnt - 8'd1;
          GAP:
            if (gcnt == '0) state <= IDLE;
            else gcnt <= gcnt - GW'(1);
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_master_multi.sv
// tb_spi_master_multi: scoreboard bench for two spi_master_multi configs (HALF=1/CPOL=0, HALF=3/CPOL=1)
module tb_spi_master_multi;
  localparam int W = 16, NCH = 2, GAP = 2;

  typedef struct {
    int ch; logic [15:0] data; logic [15:0] resp; logic [15:0] exp; int start; int rv;
  } txn_t;
  typedef struct {
    int d; int ch; logic [15:0] data; logic [15:0] resp; logic [15:0] exp;
  } vec_t;

  logic clock = 1'b0, reset_n = 1'b0;
  int cyc = 0, checks = 0, errors = 0;
  always #5 clock = ~clock;
  // Cycle counter used as the common time base for the reference model.
  always @(posedge clock) cyc <= cyc + 1;

  spi_master_multi_if #(.WIDTH(16)) if0 ();
  spi_master_multi_if #(.WIDTH(16)) if1 ();

  logic        wvalid_t [2] = '{1'b0, 1'b0};
  logic [2:0]  wchan_t  [2] = '{3'd0, 3'd0};
  logic [15:0] wdata_t  [2] = '{16'h0, 16'h0};
  logic        wready_t [2], rvalid_t [2], busy_t [2];
  logic [2:0]  rchan_t  [2];
  logic [15:0] rdata_t  [2];
  logic [1:0]  sck_p [2], cs_p [2], mosi_p [2];
  logic [1:0]  miso_p [2] = '{2'b00, 2'b00};

  assign if0.wvalid = wvalid_t[0];
  assign if0.wchan  = wchan_t[0];
  assign if0.wdata  = wdata_t[0];
  assign if1.wvalid = wvalid_t[1];
  assign if1.wchan  = wchan_t[1];
  assign if1.wdata  = wdata_t[1];
  assign wready_t[0] = if0.wready;
  assign wready_t[1] = if1.wready;
  assign rvalid_t[0] = if0.rvalid;
  assign rvalid_t[1] = if1.rvalid;
  assign busy_t[0]   = if0.busy;
  assign busy_t[1]   = if1.busy;
  assign rchan_t[0]  = if0.rchan;
  assign rchan_t[1]  = if1.rchan;
  assign rdata_t[0]  = if0.rdata;
  assign rdata_t[1]  = if1.rdata;

  spi_master_multi #(.NCH(2), .WIDTH(16), .HALF(1), .CPOL(1'b0), .CS_GAP(2)) dut0 (
    .clock(clock), .reset_n(reset_n), .bus(if0),
    .sck(sck_p[0]), .cs_n(cs_p[0]), .mosi(mosi_p[0]), .miso(miso_p[0]));
  spi_master_multi #(.NCH(2), .WIDTH(16), .HALF(3), .CPOL(1'b1), .CS_GAP(2)) dut1 (
    .clock(clock), .reset_n(reset_n), .bus(if1),
    .sck(sck_p[1]), .cs_n(cs_p[1]), .mosi(mosi_p[1]), .miso(miso_p[1]));

  function automatic int hd(int d);
    return d != 0 ? 3 : 1;
  endfunction
  function automatic logic cpv(int d);
    return d != 0;
  endfunction

  task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at cycle %0d", name, d, act, exp, cyc);
    end
  endtask

  txn_t eq [2][$];
  int last_rv [2] = '{-100, -100};
  int rv_count [2] = '{0, 0};
  int low [2][2], rises [2][2], first [2][2], stray [2][2], run [2][2];
  int last_rise [2][2], last_fall [2][2];
  logic [15:0] mw [2][2], sreg [2][2];
  logic [1:0] pcs [2], pck [2];
  txn_t mt;

  // Pin monitor, SPI slave model (CPHA 0: present on cs fall, advance on trailing edge) and rvalid scoreboard.
  always @(posedge clock) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      if (!reset_n) begin
        for (int i = 0; i < 2; i++) begin
          low[d][i] = 0; rises[d][i] = 0; stray[d][i] = 0; mw[d][i] = '0; run[d][i] = 0;
        end
        miso_p[d] = 2'b00;
        pcs[d] = 2'b11;
        pck[d] = {2{cpv(d)}};
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (!cs_p[d][i]) begin
            if (pcs[d][i]) begin
              first[d][i] = cyc;
              last_fall[d][i] = cyc;
              run[d][i] = 1;
              sreg[d][i] = eq[d].size() > 0 ? eq[d][0].resp : 16'h0;
              miso_p[d][i] = sreg[d][i][15];
            end else if (sck_p[d][i] != pck[d][i]) begin
              chk("sck_level_len", d, run[d][i], hd(d));
              run[d][i] = 1;
              if (sck_p[d][i] != cpv(d)) begin
                rises[d][i]++;
                mw[d][i] = {mw[d][i][14:0], mosi_p[d][i]};
              end else begin
                sreg[d][i] = {sreg[d][i][14:0], 1'b0};
                miso_p[d][i] = sreg[d][i][15];
              end
            end else run[d][i]++;
            low[d][i]++;
          end else begin
            if (!pcs[d][i]) begin
              last_rise[d][i] = cyc;
              chk("trail_plus_hold_len", d, run[d][i], 2 * hd(d));
            end
            if (sck_p[d][i] != cpv(d) || mosi_p[d][i]) stray[d][i]++;
          end
        end
        pcs[d] = cs_p[d];
        pck[d] = sck_p[d];
        if (rvalid_t[d]) begin
          rv_count[d]++;
          if (eq[d].size() == 0) chk("unexpected_rvalid", d, 1, 0);
          else begin
            mt = eq[d].pop_front();
            chk("rvalid_cycle", d, cyc, mt.rv);
            chk("rchan", d, rchan_t[d], mt.ch);
            chk("rdata", d, rdata_t[d], mt.exp);
            for (int i = 0; i < 2; i++) begin
              if (i == mt.ch) begin
                chk("cs_low_cycles", d, low[d][i], 2 * hd(d) * (W + 1));
                chk("sck_leading_edges", d, rises[d][i], W);
                chk("mosi_word", d, mw[d][i], mt.data);
                chk("cs_fall_cycle", d, first[d][i], mt.start);
              end else chk("unselected_cs_low", d, low[d][i], 0);
              chk("stray_pins", d, stray[d][i], 0);
              low[d][i] = 0; rises[d][i] = 0; stray[d][i] = 0; mw[d][i] = '0;
            end
          end
        end
      end
    end
  end

  // Offers a command (holding wvalid while wready is low) and records the model's expected timing.
  task automatic send(int d, int ch, logic [15:0] data, logic [15:0] resp, logic [15:0] exp);
    int k = 0;
    txn_t t;
    wvalid_t[d] = 1'b1;
    wchan_t[d] = 3'(ch);
    wdata_t[d] = data;
    while (!wready_t[d] && k < 400) begin
      @(posedge clock); #1;
      k++;
    end
    chk("wready_wait", d, wready_t[d], 1);
    if (wready_t[d]) begin
      t.ch = ch; t.data = data; t.resp = resp; t.exp = exp;
      t.start = (cyc + 1 > last_rv[d] + GAP) ? cyc + 1 : last_rv[d] + GAP;
      t.rv = t.start + 2 * hd(d) * (W + 1);
      last_rv[d] = t.rv;
      eq[d].push_back(t);
    end
    @(posedge clock); #1;
    wvalid_t[d] = 1'b0;
  endtask

  task automatic wait_idle(int d);
    int k = 0;
    while ((eq[d].size() != 0 || busy_t[d]) && k < 2000) begin
      @(posedge clock); #1;
      k++;
    end
    chk("idle_timeout", d, 32'(eq[d].size() == 0 && !busy_t[d]), 1);
  endtask

  vec_t vt [8];
  int rc;

  initial begin
    vt[0] = '{0, 0, 16'hA5C3, 16'hA5C3, 16'hA5C3};
    vt[1] = '{0, 1, 16'h5A3C, 16'h0F0F, 16'h0F0F};
    vt[2] = '{0, 5, 16'h1234, 16'h0000, 16'hFFFF};
    vt[3] = '{1, 0, 16'hA5C3, 16'hFFFF, 16'hFFFF};
    vt[4] = '{1, 1, 16'h8001, 16'h0000, 16'h0000};
    vt[5] = '{1, 7, 16'h0000, 16'h0000, 16'hFFFF};
    vt[6] = '{0, 0, 16'h0000, 16'hFFFF, 16'hFFFF};
    vt[7] = '{0, 1, 16'hFFFF, 16'h0001, 16'h0001};
    repeat (3) @(posedge clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_rvalid", d, rvalid_t[d], 0);
      chk("reset_rdata", d, rdata_t[d], 0);
      chk("reset_rchan", d, rchan_t[d], 0);
      chk("reset_busy", d, busy_t[d], 0);
      chk("reset_wready", d, wready_t[d], 1);
      chk("reset_cs_n", d, cs_p[d], 2'b11);
      chk("reset_sck", d, sck_p[d], {2{cpv(d)}});
      chk("reset_mosi", d, mosi_p[d], 2'b00);
    end
    #3 reset_n = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < 8; i++) begin
      send(vt[i].d, vt[i].ch, vt[i].data, vt[i].resp, vt[i].exp);
      wait_idle(vt[i].d);
    end
    send(0, 1, 16'h1234, 16'h00FF, 16'h00FF);
    send(0, 0, 16'hFFFF, 16'h8421, 16'h8421);
    chk("wready_drop", 0, wready_t[0], 0);
    send(0, 6, 16'h0F0F, 16'h0000, 16'hFFFF);
    wait_idle(0);
    chk("cs_gap", 0, last_fall[0][0] - last_rise[0][1], GAP);
    for (int n = 0; n < 40; n++) begin
      int d, ch;
      logic [15:0] data, resp;
      d = $urandom_range(0, 1);
      ch = $urandom_range(0, 3);
      data = 16'($urandom);
      resp = 16'($urandom);
      send(d, ch, data, resp, ch < NCH ? resp : 16'hFFFF);
      if ($urandom_range(0, 2) == 0) wait_idle(d);
    end
    wait_idle(0);
    wait_idle(1);
    send(0, 1, 16'hC0DE, 16'h1111, 16'h1111);
    repeat (9) @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    chk("midreset_cs_n", 0, cs_p[0], 2'b11);
    chk("midreset_sck", 0, sck_p[0], 2'b00);
    chk("midreset_mosi", 0, mosi_p[0], 2'b00);
    eq[0].delete();
    eq[1].delete();
    last_rv[0] = -100;
    last_rv[1] = -100;
    rc = rv_count[0];
    @(posedge clock);
    @(posedge clock);
    #3 reset_n = 1'b1;
    @(posedge clock); #1;
    chk("post_reset_wready", 0, wready_t[0], 1);
    chk("post_reset_busy", 0, busy_t[0], 0);
    chk("post_reset_rdata", 0, rdata_t[0], 0);
    chk("post_reset_rchan", 0, rchan_t[0], 0);
    repeat (50) @(posedge clock);
    #1;
    chk("no_rvalid_after_reset", 0, rv_count[0] - rc, 0);
    send(0, 0, 16'h3C5A, 16'h6996, 16'h6996);
    wait_idle(0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
